// File: rtl/pcie_us_msix_arb_pkg.sv
// Shared types and helpers for the MSI-X interrupt arbiter.
//   arb_type_e : arbitration policy selector for the arbiter sub-module
//   cnt_width  : width needed to hold 0..max_val (never less than 1 bit)
package pcie_us_msix_arb_pkg;

  typedef enum logic [0:0] {
    ARB_TYPE_PRIORITY    = 1'b0,
    ARB_TYPE_ROUND_ROBIN = 1'b1
  } arb_type_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pcie_us_msix_arb_arbiter.sv
// Request arbiter with block-driven acknowledge.
//   clk, rst          : clock, synchronous active-high reset
//   request           : one bit per requester
//   acknowledge       : the current grant was consumed; advances round-robin state
//   grant             : one-hot combinational grant
//   grant_valid       : at least one request present
//   grant_encoded     : index of the granted requester
// Round-robin keeps a mask of the requesters that still have priority over
// the fallback scan; an empty masked set falls back to plain fixed priority,
// which is what makes the pointer wrap.
module pcie_us_msix_arb_arbiter
  import pcie_us_msix_arb_pkg::*;
#(
  parameter int        PORTS             = 8,
  parameter arb_type_e ARB_TYPE          = ARB_TYPE_ROUND_ROBIN,
  parameter bit        LSB_HIGH_PRIORITY = 1'b1,
  localparam int       IDX_W             = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic             acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  logic [PORTS-1:0] rr_mask_q, rr_mask_d;
  logic [PORTS-1:0] masked_req, sel_req;
  logic [PORTS-1:0] ack_mask;

  // Mask that would apply after acknowledging the current grant: only the
  // requesters "after" the winner keep precedence.
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_ack_mask
      if (LSB_HIGH_PRIORITY) begin : g_lsb
        assign ack_mask[gi] = IDX_W'(gi) > grant_encoded;
      end else begin : g_msb
        assign ack_mask[gi] = IDX_W'(gi) < grant_encoded;
      end
    end
  endgenerate

  always_comb begin
    masked_req    = request & rr_mask_q;
    sel_req       = request;
    grant_valid   = 1'b0;
    grant_encoded = '0;
    if (ARB_TYPE == ARB_TYPE_ROUND_ROBIN && |masked_req) begin
      sel_req = masked_req;
    end
    // Scan from the lowest-priority end so the highest-priority hit wins last.
    for (int k = 0; k < PORTS; k++) begin
      if (sel_req[LSB_HIGH_PRIORITY ? (PORTS - 1 - k) : k]) begin
        grant_valid   = 1'b1;
        grant_encoded = IDX_W'(LSB_HIGH_PRIORITY ? (PORTS - 1 - k) : k);
      end
    end
    grant = '0;
    if (grant_valid) begin
      grant[grant_encoded] = 1'b1;
    end
  end

  always_comb begin
    rr_mask_d = rr_mask_q;
    if (acknowledge && grant_valid) begin
      rr_mask_d = ack_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_mask_q <= '1;
    end else begin
      rr_mask_q <= rr_mask_d;
    end
  end

endmodule

// File: rtl/pcie_us_msix_arb.sv
// MSI-X interrupt arbiter for the UltraScale PCIe configuration interrupt port.
//   clk, rst                     : clock, synchronous active-high reset
//   s_irq_addr/data/valid/ready  : per-channel MSI-X message requests
//   cfg_interrupt_msix_enable/mask : core MSI-X state (bit 0 used)
//   cfg_interrupt_msix_address/data/int : message issued to the core
//   cfg_interrupt_msix_sent/fail : completion status from the core
//   cfg_interrupt_msi_function_number : constant FUNC_NUM
//   stat_drop                    : one-cycle pulse when a channel's message is dropped
//   stat_busy                    : a message is in flight
// One message is in flight at a time: it is issued, waited on, retried after
// a backoff on fail/timeout, and dropped once the retry budget is exhausted.
module pcie_us_msix_arb
  import pcie_us_msix_arb_pkg::*;
#(
  parameter int         IRQ_CHANNELS = 8,
  parameter int         RETRY_LIMIT  = 3,
  parameter int         RETRY_DELAY  = 64,
  parameter int         WAIT_TIMEOUT = 1024,
  parameter logic [7:0] FUNC_NUM     = 8'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IRQ_CHANNELS*64-1:0] s_irq_addr,
  input  logic [IRQ_CHANNELS*32-1:0] s_irq_data,
  input  logic [IRQ_CHANNELS-1:0]    s_irq_valid,
  output logic [IRQ_CHANNELS-1:0]    s_irq_ready,
  input  logic [3:0]                 cfg_interrupt_msix_enable,
  input  logic [3:0]                 cfg_interrupt_msix_mask,
  output logic [63:0]                cfg_interrupt_msix_address,
  output logic [31:0]                cfg_interrupt_msix_data,
  output logic                       cfg_interrupt_msix_int,
  output logic [7:0]                 cfg_interrupt_msi_function_number,
  input  logic                       cfg_interrupt_msix_sent,
  input  logic                       cfg_interrupt_msix_fail,
  output logic [IRQ_CHANNELS-1:0]    stat_drop,
  output logic                       stat_busy
);

  localparam int CH_W    = (IRQ_CHANNELS > 1) ? $clog2(IRQ_CHANNELS) : 1;
  localparam int RETRY_W = cnt_width(RETRY_LIMIT);
  localparam int TMO_W   = cnt_width(WAIT_TIMEOUT);
  localparam int DLY_W   = cnt_width(RETRY_DELAY);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_BACKOFF} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [DLY_W-1:0]        dly_q, dly_d;
  logic [IRQ_CHANNELS-1:0] drop_q, drop_d;

  logic [IRQ_CHANNELS-1:0] grant;
  logic                    grant_valid;
  logic [CH_W-1:0]         grant_idx;
  logic                    irq_enabled;
  logic                    accept;
  logic                    dly_done;
  logic                    unused_cfg;

  assign irq_enabled = cfg_interrupt_msix_enable[0] && !cfg_interrupt_msix_mask[0];
  // Gating with rst keeps ready low while reset is held even though the
  // state register already reads IDLE.
  assign accept      = (state_q == ST_IDLE) && irq_enabled && grant_valid && !rst;
  assign s_irq_ready = accept ? grant : '0;
  assign dly_done    = ({1'b0, dly_q} + 1'b1) >= (DLY_W + 1)'(RETRY_DELAY);
  assign unused_cfg  = ^{cfg_interrupt_msix_enable[3:1], cfg_interrupt_msix_mask[3:1]};

  pcie_us_msix_arb_arbiter #(
    .PORTS            (IRQ_CHANNELS),
    .ARB_TYPE         (ARB_TYPE_ROUND_ROBIN),
    .LSB_HIGH_PRIORITY(1'b1)
  ) u_arbiter (
    .clk          (clk),
    .rst          (rst),
    .request      (s_irq_valid),
    .acknowledge  (accept),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_encoded(grant_idx)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    dly_d   = dly_q;
    drop_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          addr_d  = s_irq_addr[int'(grant_idx)*64 +: 64];
          data_d  = s_irq_data[int'(grant_idx)*32 +: 32];
          chan_d  = grant_idx;
          retry_d = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        // Sent has precedence, so sent+fail together completes the message.
        if (cfg_interrupt_msix_sent) begin
          state_d = ST_IDLE;
        end else if (cfg_interrupt_msix_fail || tmo_q == TMO_W'(WAIT_TIMEOUT)) begin
          if (retry_q < RETRY_W'(RETRY_LIMIT)) begin
            state_d = ST_BACKOFF;
            retry_d = retry_q + 1'b1;
            dly_d   = '0;
          end else begin
            state_d        = ST_IDLE;
            drop_d[chan_q] = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        // Once the delay has elapsed the counter parks; the request is held
        // until the core re-enables/unmasks MSI-X.
        if (dly_done) begin
          if (irq_enabled) begin
            state_d = ST_ISSUE;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      dly_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      dly_q   <= dly_d;
      drop_q  <= drop_d;
    end
  end

  assign cfg_interrupt_msix_address        = addr_q;
  assign cfg_interrupt_msix_data           = data_q;
  assign cfg_interrupt_msix_int            = (state_q == ST_ISSUE);
  assign cfg_interrupt_msi_function_number = FUNC_NUM;
  assign stat_drop                         = drop_q;
  assign stat_busy                         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_us_msix_arb.sv
module tb_pcie_us_msix_arb;
  localparam int         N  = 4;
  localparam int         RL = 3;
  localparam int         RD = 8;
  localparam int         WT = 20;
  localparam logic [7:0] FN = 8'hA5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [63:0]      ch_addr [N];
  logic [31:0]      ch_data [N];
  logic [N*64-1:0]  s_irq_addr;
  logic [N*32-1:0]  s_irq_data;
  logic [N-1:0]     s_irq_valid = '0;
  logic [N-1:0]     s_irq_ready;
  logic [3:0]       en = 4'h1;
  logic [3:0]       msk = 4'h0;
  logic [63:0]      addr_o;
  logic [31:0]      data_o;
  logic             int_o;
  logic [7:0]       fn_o;
  logic             sent = 1'b0;
  logic             fail = 1'b0;
  logic [N-1:0]     drop;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int last_ch = N - 1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign s_irq_addr[gi*64 +: 64] = ch_addr[gi];
      assign s_irq_data[gi*32 +: 32] = ch_data[gi];
    end
  endgenerate

  always #5 clk = ~clk;

  pcie_us_msix_arb #(
    .IRQ_CHANNELS(N), .RETRY_LIMIT(RL), .RETRY_DELAY(RD),
    .WAIT_TIMEOUT(WT), .FUNC_NUM(FN)
  ) dut (
    .clk(clk), .rst(rst),
    .s_irq_addr(s_irq_addr), .s_irq_data(s_irq_data),
    .s_irq_valid(s_irq_valid), .s_irq_ready(s_irq_ready),
    .cfg_interrupt_msix_enable(en), .cfg_interrupt_msix_mask(msk),
    .cfg_interrupt_msix_address(addr_o), .cfg_interrupt_msix_data(data_o),
    .cfg_interrupt_msix_int(int_o), .cfg_interrupt_msi_function_number(fn_o),
    .cfg_interrupt_msix_sent(sent), .cfg_interrupt_msix_fail(fail),
    .stat_drop(drop), .stat_busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requester found walking forward from the one
  // after the last grant.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle with the request already on s_irq_valid.
  task automatic serve_one(input int ch, input int wait_cycles, input bit both);
    logic [N-1:0] oh;
    logic [63:0]  a;
    logic [31:0]  d;
    oh = '0;
    if (ch >= 0) oh[ch] = 1'b1;
    a = (ch >= 0) ? ch_addr[ch] : '0;
    d = (ch >= 0) ? ch_data[ch] : '0;
    #1;
    check("ready_grant", s_irq_ready, oh);
    check("int_in_accept", int_o, 1'b0);
    tick();
    if (ch >= 0) s_irq_valid[ch] = 1'b0;
    #1;
    check("int_issue", int_o, 1'b1);
    check("addr_issue", addr_o, a);
    check("data_issue", data_o, d);
    check("busy_issue", busy, 1'b1);
    for (int k = 0; k < wait_cycles; k++) begin
      tick();
      #1;
      check("int_wait", int_o, 1'b0);
      check("addr_hold", addr_o, a);
      check("data_hold", data_o, d);
    end
    tick();
    sent = 1'b1;
    fail = both;
    #1;
    check("int_at_sent", int_o, 1'b0);
    tick();
    sent = 1'b0;
    fail = 1'b0;
    #1;
    check("idle_after_sent", busy, 1'b0);
    check("drop_after_sent", drop, '0);
    $display("txn ch=%0d addr=0x%0h data=0x%0h wait=%0d both=%0d", ch, a, d, wait_cycles, both);
  endtask

  int         exp_ch;
  int         cnt;
  logic [N-1:0] seen;
  int         int_t[$];
  int         drop_t;
  int         drop_n;
  logic [N-1:0] drop_seen;
  bit         prev_int;
  logic [N-1:0] add;

  initial begin
    for (int c = 0; c < N; c++) begin
      ch_addr[c] = 64'h0000_0000_FEE0_0000 + 64'(c * 16);
      ch_data[c] = 32'(c + 16);
    end

    // Reset state, with requests pending while reset is held.
    tick();
    tick();
    s_irq_valid = '1;
    #1;
    check("rst_ready", s_irq_ready, '0);
    check("rst_int", int_o, 1'b0);
    check("rst_addr", addr_o, '0);
    check("rst_data", data_o, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop, '0);
    check("func_num", fn_o, FN);
    s_irq_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Channels 0,1,3 together, then 0 and 3 again.
    s_irq_valid = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      exp_ch = rr_pick(s_irq_valid, last_ch);
      serve_one(exp_ch, 0, 1'b0);
      last_ch = exp_ch;
    end
    s_irq_valid = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      exp_ch = rr_pick(s_irq_valid, last_ch);
      serve_one(exp_ch, 0, 1'b0);
      last_ch = exp_ch;
    end

    // Channel 2, sent three cycles after int.
    ch_addr[2] = 64'h0000_0000_FEE0_0000;
    ch_data[2] = 32'h41;
    s_irq_valid[2] = 1'b1;
    exp_ch = rr_pick(s_irq_valid, last_ch);
    serve_one(exp_ch, 2, 1'b0);
    last_ch = exp_ch;

    // Fail on every issue: RL+1 issues then a single drop.
    int_t.delete();
    drop_n = 0;
    drop_t = -1;
    drop_seen = '0;
    prev_int = 1'b0;
    s_irq_valid[1] = 1'b1;
    #1;
    check("ready_retry", s_irq_ready, 4'b0010);
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      s_irq_valid[1] = 1'b0;
      fail = prev_int;
      #1;
      prev_int = int_o;
      if (int_o) int_t.push_back(cyc);
      if (drop != '0) begin
        drop_n++;
        drop_t = cyc;
        drop_seen |= drop;
      end
    end
    fail = 1'b0;
    last_ch = 1;
    check("retry_int_count", 64'(int_t.size()), 64'(RL + 1));
    for (int i = 1; i < int_t.size(); i++)
      check("retry_gap", 64'(int_t[i] - int_t[i-1]), 64'(RD + 2));
    check("drop_count", 64'(drop_n), 64'd1);
    check("drop_channel", drop_seen, 4'b0010);
    if (int_t.size() > 0)
      check("drop_time", 64'(drop_t), 64'(int_t[int_t.size()-1] + 2));
    check("busy_after_drop", busy, 1'b0);

    // Timeout re-issue, hold in backoff while masked, then sent+fail together.
    int_t.delete();
    s_irq_valid[0] = 1'b1;
    #1;
    check("ready_tmo", s_irq_ready, 4'b0001);
    tick();
    s_irq_valid[0] = 1'b0;
    last_ch = 0;
    #1;
    if (int_o) int_t.push_back(0);
    for (int cyc = 1; cyc < 200 && int_t.size() < 2; cyc++) begin
      tick();
      #1;
      if (int_o) int_t.push_back(cyc);
    end
    check("tmo_int_count", 64'(int_t.size()), 64'd2);
    if (int_t.size() == 2)
      check("tmo_gap", 64'(int_t[1] - int_t[0]), 64'(WT + RD + 2));
    tick();
    fail = 1'b1;
    #1;
    check("int_wait2", int_o, 1'b0);
    tick();
    fail = 1'b0;
    msk = 4'h1;
    cnt = 0;
    for (int k = 0; k < RD + 6; k++) begin
      #1;
      if (int_o) cnt++;
      tick();
    end
    check("hold_masked_ints", 64'(cnt), 64'd0);
    check("hold_masked_busy", busy, 1'b1);
    msk = 4'h0;
    tick();
    #1;
    check("release_int", int_o, 1'b1);
    tick();
    sent = 1'b1;
    fail = 1'b1;
    tick();
    sent = 1'b0;
    fail = 1'b0;
    #1;
    check("both_idle", busy, 1'b0);
    cnt = 0;
    for (int k = 0; k < RD + WT; k++) begin
      tick();
      #1;
      if (int_o || drop != '0) cnt++;
    end
    check("both_no_retry", 64'(cnt), 64'd0);

    // Masked / disabled: nothing accepted until cleared.
    msk = 4'h1;
    s_irq_valid[3] = 1'b1;
    seen = '0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      seen |= s_irq_ready;
      if (int_o) cnt++;
    end
    check("mask_ready", seen, '0);
    check("mask_int", 64'(cnt), 64'd0);
    msk = 4'h0;
    exp_ch = rr_pick(s_irq_valid, last_ch);
    serve_one(exp_ch, 1, 1'b0);
    last_ch = exp_ch;

    en = 4'h2;
    s_irq_valid[2] = 1'b1;
    seen = '0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      seen |= s_irq_ready;
      if (int_o) cnt++;
    end
    check("disable_ready", seen, '0);
    check("disable_int", 64'(cnt), 64'd0);
    en = 4'h1;
    exp_ch = rr_pick(s_irq_valid, last_ch);
    serve_one(exp_ch, 0, 1'b0);
    last_ch = exp_ch;

    // Reset while waiting on the core.
    s_irq_valid[2] = 1'b1;
    #1;
    check("ready_rst_mid", s_irq_ready, 4'b0100);
    tick();
    s_irq_valid[2] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    fail = 1'b1;
    s_irq_valid = 4'b0101;
    tick();
    fail = 1'b0;
    #1;
    check("rstmid_int", int_o, 1'b0);
    check("rstmid_addr", addr_o, '0);
    check("rstmid_data", data_o, '0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_drop", drop, '0);
    check("rstmid_ready", s_irq_ready, '0);
    tick();
    #1;
    check("rstmid_drop2", drop, '0);
    rst = 1'b0;
    last_ch = N - 1;
    for (int i = 0; i < 2; i++) begin
      exp_ch = rr_pick(s_irq_valid, last_ch);
      serve_one(exp_ch, 0, 1'b0);
      last_ch = exp_ch;
    end

    // Randomized traffic against the round-robin model.
    for (int t = 0; t < 25; t++) begin
      add = N'($urandom_range(0, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        if (add[c] && !s_irq_valid[c]) begin
          ch_addr[c] = {$urandom, $urandom};
          ch_data[c] = $urandom;
        end
      end
      s_irq_valid = s_irq_valid | add;
      if (s_irq_valid == '0) s_irq_valid[$urandom_range(0, N - 1)] = 1'b1;
      exp_ch = rr_pick(s_irq_valid, last_ch);
      serve_one(exp_ch, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      last_ch = exp_ch;
    end

    s_irq_valid = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_us_msix_arb.md
PCIE_US_MSIX_ARB -- requirements
Module: pcie_us_msix_arb

Interface
REQ-001 SHALL have parameter IRQ_CHANNELS, default 8, number of independent MSI-X requesters (1-32).
REQ-002 SHALL have parameter RETRY_LIMIT, default 3, number of re-issues after fail before a drop.
REQ-003 SHALL have parameter RETRY_DELAY, default 64, backoff cycles between fail and re-issue.
REQ-004 SHALL have parameter WAIT_TIMEOUT, default 1024, cycles without sent/fail before the request is treated as failed.
REQ-005 SHALL have parameter FUNC_NUM, default 8'd0, value driven on cfg_interrupt_msi_function_number.
REQ-006 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: s_irq_addr in IRQ_CHANNELS*64, per-channel message address; s_irq_data in IRQ_CHANNELS*32, per-channel message data.
REQ-008 SHALL have ports: s_irq_valid in IRQ_CHANNELS, request valid; s_irq_ready out IRQ_CHANNELS, request accepted.
REQ-009 SHALL have ports: cfg_interrupt_msix_enable in 4; cfg_interrupt_msix_mask in 4 (bit 0 used).
REQ-010 SHALL have ports: cfg_interrupt_msix_address out 64; cfg_interrupt_msix_data out 32; cfg_interrupt_msix_int out 1; cfg_interrupt_msi_function_number out 8.
REQ-011 SHALL have ports: cfg_interrupt_msix_sent in 1; cfg_interrupt_msix_fail in 1.
REQ-012 SHALL have ports: stat_drop out IRQ_CHANNELS, one-cycle pulse on channel drop; stat_busy out 1, state != IDLE.

Function
REQ-013 SHALL select among asserted s_irq_valid by round-robin; priority starts at channel index after last granted; after reset channel 0 highest.
REQ-014 SHALL accept a request only in IDLE with enable[0]=1 and mask[0]=0; s_irq_ready[i] pulses one cycle for granted i, at most one bit per cycle; s_irq_ready is combinational on s_irq_valid.
REQ-015 SHALL capture address/data of the granted channel into registers on acceptance and hold them stable on the cfg outputs until return to IDLE.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, BACKOFF.
REQ-017 IDLE->ISSUE on acceptance; ISSUE drives cfg_interrupt_msix_int high exactly one cycle, then ->WAIT.
REQ-018 WAIT: sent -> IDLE; fail or timeout counter reaching WAIT_TIMEOUT -> BACKOFF if retry count < RETRY_LIMIT, else pulse stat_drop[channel] and ->IDLE.
REQ-019 BACKOFF: count RETRY_DELAY cycles, then ->ISSUE only if enable[0]=1 and mask[0]=0, else stay in BACKOFF holding the request.
REQ-020 Retry count SHALL be $clog2(RETRY_LIMIT+1) bits, cleared on acceptance, incremented on each entry to BACKOFF.
REQ-021 Sent and fail asserted in same cycle SHALL be treated as sent.
REQ-022 Sent/fail outside WAIT SHALL be ignored.
REQ-023 Latency valid->int SHALL be 2 cycles (accept cycle, ISSUE cycle) when idle and enabled.
REQ-024 cfg_interrupt_msi_function_number SHALL be constant FUNC_NUM.
REQ-025 Timeout counter SHALL reset on every entry to WAIT; width $clog2(WAIT_TIMEOUT+1).

Reset
REQ-026 On rst: state IDLE, msix_int 0, address/data 0, s_irq_ready 0, stat_drop 0, stat_busy 0, counters 0, RR pointer to channel 0.
REQ-027 Reset mid-operation SHALL abandon the in-flight request without stat_drop and without msix_int in the following cycle.

Structure
REQ-028 State encoding and counter-width localparams SHALL be local; no shared package needed beyond existing codebase header.
REQ-029 Round-robin selection SHALL use the existing arbiter sub-module (arbiter, ARB_TYPE_ROUND_ROBIN, LSB_HIGH_PRIORITY) with block-driven acknowledge.

Verification
REQ-030 Channel 2 valid, addr 0xFEE0_0000, data 0x41, sent 3 cycles after int -> int one cycle at t+2, outputs stable, IDLE after sent.
REQ-031 Channels 0,1,3 valid together, immediate sent each -> grant order 0,1,3; then ch0 and ch3 again -> order 3,0? no: order 0 after 3 wraps -> 0,3.
REQ-032 Fail on every issue, RETRY_LIMIT=3 -> 4 int pulses spaced >=RETRY_DELAY+1 cycles, then stat_drop[ch] one pulse.
REQ-033 mask[0]=1 with channel valid -> no ready, no int; clear mask -> int 2 cycles later.
REQ-034 No sent/fail for WAIT_TIMEOUT cycles -> BACKOFF then re-issue; sent+fail same cycle -> IDLE, no retry.
REQ-035 rst asserted in WAIT -> next cycle all outputs reset values, no stat_drop.
